// File: rtl/md_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide issue controller.
package md_pkg;

  localparam int unsigned MD_DATA_W       = 32;
  localparam int unsigned MD_OP_W         = 4;
  localparam int unsigned MD_XOP_W        = 3;
  localparam int unsigned MD_BUSY_TIMEOUT = 16;
  localparam int unsigned MD_CNT_W        = 32;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [MD_XOP_W-1:0] {
    XOP_MULT  = 3'd0,
    XOP_MULTU = 3'd1,
    XOP_DIV   = 3'd2,
    XOP_DIVU  = 3'd3,
    XOP_MTHI  = 3'd4,
    XOP_MTLO  = 3'd5
  } xalu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [MD_XOP_W-1:0]  op;
    logic [MD_DATA_W-1:0] rd1;
    logic [MD_DATA_W-1:0] rd2;
  } md_issue_t;

  // E-stage classes 1..6 map one-to-one onto XALU ops 0..5.
  function automatic logic [MD_XOP_W-1:0] md_to_xop(input logic [MD_OP_W-1:0] op);
    return MD_XOP_W'(op - 4'd1);
  endfunction

endpackage

// File: rtl/md_timeout_cnt.sv
// Saturating BUSY-window watchdog with a sticky error flag.
module md_timeout_cnt
  import md_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = MD_BUSY_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit_c,
  output logic o_err
);

  localparam int unsigned TCNT_W = $clog2(BUSY_TIMEOUT + 1);

  logic [TCNT_W-1:0] r_cnt;
  logic              r_err;

  // Fires on the increment that brings the count up to the limit.
  assign o_hit_c = i_inc && (r_cnt >= TCNT_W'(BUSY_TIMEOUT - 1));
  assign o_err   = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && (r_cnt != TCNT_W'(BUSY_TIMEOUT))) begin
        r_cnt <= r_cnt + TCNT_W'(1);
      end
      if (o_hit_c) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller feeding the XALU mult/div unit; stalls HI/LO ops while it is occupied.
// Optional performance counters are enabled with `define MD_PERF_CNT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = MD_BUSY_TIMEOUT
`ifdef MD_PERF_CNT_EN
  , parameter int unsigned CNT_W = MD_CNT_W
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [MD_OP_W-1:0]   MDOp_E,
  input  logic                 Valid_E,
  input  logic                 Flush,
  input  logic [MD_DATA_W-1:0] RD1_E,
  input  logic [MD_DATA_W-1:0] RD2_E,
  input  logic                 XBusy,
  output logic                 XStart,
  output logic [MD_XOP_W-1:0]  XALUOp,
  output logic [MD_DATA_W-1:0] XRD1,
  output logic [MD_DATA_W-1:0] XRD2,
  output logic                 Stall,
  output logic                 Err
`ifdef MD_PERF_CNT_EN
  , output logic [CNT_W-1:0]   IssueCnt
  , output logic [CNT_W-1:0]   StallCnt
`endif
);

  md_state_e r_state;
  md_state_e w_state_nxt;
  md_issue_t r_issue;
  md_issue_t w_issue_nxt;
  logic      r_xstart;
  logic      w_load;
  logic      w_md_req;
  logic      w_issue_req;
  logic      w_timeout_hit;
  logic      w_in_busy;

  always_comb begin
    w_md_req    = Valid_E && !Flush &&
                  (MDOp_E >= MD_OP_W'(MD_MULT)) && (MDOp_E <= MD_OP_W'(MD_MFLO));
    w_issue_req = w_md_req && (MDOp_E <= MD_OP_W'(MD_MTLO));
  end

  assign w_in_busy = (r_state == ST_BUSY);
  assign Stall     = w_md_req && ((r_state == ST_ISSUE) || (w_in_busy && XBusy));

  // Next-state: a pending issue may launch straight out of BUSY when XBusy drops.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue_nxt = '{op: md_to_xop(MDOp_E), rd1: RD1_E, rd2: RD2_E};
    case (r_state)
      ST_IDLE: begin
        if (w_issue_req) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = (r_issue.op >= MD_XOP_W'(XOP_MTHI)) ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (!XBusy) begin
          if (w_issue_req) begin
            w_load      = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_xstart <= 1'b0;
      r_issue  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_xstart <= w_load;
      if (w_load) begin
        r_issue <= w_issue_nxt;
      end
    end
  end

  md_timeout_cnt #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) u_timeout (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_clr   (!w_in_busy),
    .i_inc   (w_in_busy && XBusy),
    .o_hit_c (w_timeout_hit),
    .o_err   (Err)
  );

  assign XStart = r_xstart;
  assign XALUOp = r_issue.op;
  assign XRD1   = r_issue.rd1;
  assign XRD2   = r_issue.rd2;

`ifdef MD_PERF_CNT_EN
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (Stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign IssueCnt = r_issue_cnt;
  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized and directed bench for md_issue_ctrl against a behavioural pipeline/XALU model.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int TIMEOUT = 16;

  logic        Clock;
  logic        Reset;
  logic [3:0]  MDOp_E;
  logic        Valid_E;
  logic        Flush;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic        XBusy;
  logic        XStart;
  logic [2:0]  XALUOp;
  logic [31:0] XRD1;
  logic [31:0] XRD2;
  logic        Stall;
  logic        Err;
`ifdef MD_PERF_CNT_EN
  logic [31:0] IssueCnt;
  logic [31:0] StallCnt;
`endif

  md_issue_ctrl dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .MDOp_E  (MDOp_E),
    .Valid_E (Valid_E),
    .Flush   (Flush),
    .RD1_E   (RD1_E),
    .RD2_E   (RD2_E),
    .XBusy   (XBusy),
    .XStart  (XStart),
    .XALUOp  (XALUOp),
    .XRD1    (XRD1),
    .XRD2    (XRD2),
    .Stall   (Stall),
    .Err     (Err)
`ifdef MD_PERF_CNT_EN
    , .IssueCnt (IssueCnt)
    , .StallCnt (StallCnt)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: what the unit is doing, in pipeline terms.
  logic        m_start;      // a start pulse is on the wire this cycle
  logic        m_wait;       // a long op has been started and the unit may still be busy
  logic [2:0]  m_op;
  logic [31:0] m_rd1, m_rd2;
  logic        m_err;
  int          m_tcnt;
  logic [31:0] m_icnt, m_scnt;

  // XALU stand-in.
  int   busy_rem;
  int   next_lat;
  logic stuck;

  logic last_stall;
  logic prev_start;
  int   stall_cycles;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_start = 1'b0; m_wait = 1'b0; m_op = '0; m_rd1 = '0; m_rd2 = '0;
    m_err = 1'b0; m_tcnt = 0; m_icnt = '0; m_scnt = '0;
    busy_rem = 0; stuck = 1'b0; XBusy = 1'b0; prev_start = 1'b0; last_stall = 1'b0;
  endtask

  task automatic launch();
    m_start = 1'b1;
    m_op    = 3'(MDOp_E - 4'd1);
    m_rd1   = RD1_E;
    m_rd2   = RD2_E;
  endtask

  // One clock cycle: inputs are already set, we sit 1 time unit after the rising edge.
  task automatic cycle();
    logic md_req, iss_req, exp_stall, s_start, xb;
    logic [2:0] s_op;
    #3;
    md_req    = Valid_E && !Flush && (MDOp_E >= 4'd1) && (MDOp_E <= 4'd8);
    iss_req   = md_req && (MDOp_E <= 4'd6);
    exp_stall = md_req && (m_start || (m_wait && XBusy));
    chk("stall",  Stall,  exp_stall);
    chk("xstart", XStart, m_start);
    chk("xaluop", XALUOp, m_op);
    chk("xrd1",   XRD1,   m_rd1);
    chk("xrd2",   XRD2,   m_rd2);
    chk("err",    Err,    m_err);
    chk("xstart_gap", prev_start & XStart, 1'b0);
`ifdef MD_PERF_CNT_EN
    chk("issue_cnt", IssueCnt, m_icnt);
    chk("stall_cnt", StallCnt, m_scnt);
`endif
    if (exp_stall) stall_cycles++;
    last_stall = exp_stall;
    prev_start = XStart;
    s_start = XStart; s_op = XALUOp; xb = XBusy;
    @(posedge Clock);
    if (exp_stall) m_scnt = m_scnt + 32'd1;
    if (m_start)   m_icnt = m_icnt + 32'd1;
    if (m_start) begin
      m_start = 1'b0;
      m_wait  = (m_op < 3'd4);
      m_tcnt  = 0;
    end else if (m_wait) begin
      if (!xb) begin
        m_wait = 1'b0;
        if (iss_req) launch();
      end else begin
        m_tcnt++;
        if (m_tcnt >= TIMEOUT) begin
          m_err  = 1'b1;
          m_wait = 1'b0;
        end
      end
    end else if (iss_req) begin
      launch();
    end
    #1;
    if (xb && busy_rem > 0) busy_rem--;
    if (s_start && s_op < 3'd4) busy_rem = next_lat;
    XBusy = stuck || (busy_rem > 0);
  endtask

  task automatic idle(input int n);
    Valid_E = 1'b0; Flush = 1'b0; MDOp_E = 4'd0;
    repeat (n) cycle();
  endtask

  // Present an op and hold it in E while the pipeline is stalled.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    Valid_E = 1'b1; Flush = 1'b0; MDOp_E = op; RD1_E = a; RD2_E = b;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (last_stall && guard < 64);
    if (last_stall) chk("hold_bound", 1'b1, 1'b0);
    Valid_E = 1'b0; MDOp_E = 4'd0;
  endtask

  task automatic async_reset();
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_xstart", XStart, 1'b0);
    chk("rst_xaluop", XALUOp, 3'd0);
    chk("rst_xrd1",   XRD1,   32'd0);
    chk("rst_xrd2",   XRD2,   32'd0);
    chk("rst_stall",  Stall,  1'b0);
    chk("rst_err",    Err,    1'b0);
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; Valid_E = 1'b0; Flush = 1'b0; MDOp_E = 4'd0;
    RD1_E = '0; RD2_E = '0; XBusy = 1'b0; next_lat = 5; stall_cycles = 0;
    model_reset();
    @(posedge Clock); #1;
    async_reset();
    idle(2);

    // mult -7 * 13, then mflo waits out ISSUE plus a 5-cycle busy window.
    next_lat = 5;
    run_op(4'(MD_MULT), 32'hFFFF_FFF9, 32'd13);
    chk("s1_xrd1", XRD1, 32'hFFFF_FFF9);
    stall_cycles = 0;
    run_op(4'(MD_MFLO), 32'd0, 32'd0);
    chk("s1_mflo_stalls", 64'(stall_cycles), 64'd6);
    idle(3);

    // div 8/3 then a stalled divu issues as soon as XBusy drops.
    next_lat = 4;
    run_op(4'(MD_DIV), 32'd8, 32'd3);
    stall_cycles = 0;
    run_op(4'(MD_DIVU), 32'd100, 32'd7);
    chk("b2b_stalls", 64'(stall_cycles), 64'd5);
    idle(8);

    // mthi then mtlo back to back: one ISSUE-cycle stall, no BUSY.
    run_op(4'(MD_MTHI), 32'd100, 32'd0);
    stall_cycles = 0;
    run_op(4'(MD_MTLO), 32'd300, 32'd0);
    chk("mtlo_stalls", 64'(stall_cycles), 64'd1);
    chk("mtlo_op", XALUOp, 3'(XOP_MTLO));
    idle(3);

    // Flushed multu neither issues nor stalls; a flush during BUSY changes nothing.
    Valid_E = 1'b1; Flush = 1'b1; MDOp_E = 4'(MD_MULTU); RD1_E = 32'hDEAD; RD2_E = 32'hBEEF;
    repeat (2) cycle();
    next_lat = 6;
    run_op(4'(MD_MULT), 32'd3, 32'd4);
    Valid_E = 1'b1; Flush = 1'b1; MDOp_E = 4'(MD_MULTU);
    repeat (4) cycle();
    idle(6);

    // XBusy stuck high: watchdog trips after 16 busy cycles.
    stuck = 1'b1; XBusy = 1'b1;
    run_op(4'(MD_MULT), 32'd1, 32'd2);
    idle(20);
    chk("err_set", Err, 1'b1);
    stuck = 1'b0;
    idle(3);
    chk("err_sticky", Err, 1'b1);

    // Randomized traffic, stalled instructions held in E.
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        Valid_E = ($urandom_range(0, 9) < 8);
        Flush   = ($urandom_range(0, 9) == 0);
        MDOp_E  = 4'($urandom_range(0, 15));
        RD1_E   = $urandom;
        RD2_E   = $urandom;
      end
      next_lat = $urandom_range(1, 6);
      cycle();
    end
    idle(10);

    // Asynchronous reset in the middle of a long divu.
    next_lat = 10;
    run_op(4'(MD_DIVU), 32'h1234_5678, 32'd5);
    idle(3);
    async_reset();
    idle(2);
    next_lat = 2;
    run_op(4'(MD_MULTU), 32'd9, 32'd9);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
